// File: rtl/instr_mem_responder.sv
// Instruction fetch responder: valid/ready request in, fixed wait states, valid/ready word out.
// A side load port fills the word array; array contents survive reset.
module instr_mem_responder #(
   parameter int unsigned DEPTH_LOG2  = 8,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] FILL_INSTR  = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [31:0]           req_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_instr,
   output logic [31:0]           rsp_addr,
   output logic                  rsp_err,
   input  logic                  ld_en,
   input  logic [DEPTH_LOG2-1:0] ld_addr,
   input  logic [31:0]           ld_data
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    req_ready_q, req_ready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [31:0]             rsp_instr_q, rsp_instr_d;
   logic [31:0]             rsp_addr_q, rsp_addr_d;
   logic                    rsp_err_q, rsp_err_d;
   logic [31:0]             mem_q [DEPTH];

   logic [DEPTH_LOG2-1:0]   req_idx;
   logic [DEPTH_LOG2-1:0]   rsp_idx;
   logic                    req_err;
   logic                    accept;

   assign req_idx = req_addr[DEPTH_LOG2+1:2];
   assign rsp_idx = rsp_addr_q[DEPTH_LOG2+1:2];
   assign req_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
   assign accept  = req_ready_q && req_valid;

   // Next state, wait counter and response payload
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_instr_d = rsp_instr_q;
      rsp_addr_d  = rsp_addr_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               rsp_addr_d = req_addr;
               if (req_err) begin
                  rsp_instr_d = FILL_INSTR;
                  rsp_err_d   = 1'b1;
                  state_d     = RESP;
               end else if (WAIT_CYCLES == 0) begin
                  rsp_instr_d = mem_q[req_idx];
                  rsp_err_d   = 1'b0;
                  state_d     = RESP;
               end else begin
                  cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               rsp_instr_d = mem_q[rsp_idx];
               rsp_err_d   = 1'b0;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Handshake flags are registered decodes; rsp_valid trails RESP entry by one edge
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_q == RESP) && !(rsp_valid_q && rsp_ready);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_instr_q <= FILL_INSTR;
         rsp_addr_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_instr_q <= rsp_instr_d;
         rsp_addr_q  <= rsp_addr_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Load port; captures above read the pre-write contents on a shared edge
   always_ff @(posedge clk) begin
      if (rst && ld_en) begin
         mem_q[ld_addr] <= ld_data;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_instr = rsp_instr_q;
   assign rsp_addr  = rsp_addr_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: directed fetches with a scoreboard queue checked by a response monitor.
module tb_instr_mem_responder;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic [31:0] rsp_addr;
   logic        rsp_err;
   logic        ld_en;
   logic [7:0]  ld_addr;
   logic [31:0] ld_data;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   instr_mem_responder #(
      .DEPTH_LOG2 (8),
      .WAIT_CYCLES(2),
      .FILL_INSTR (32'h0000_0013)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr (req_addr),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_instr(rsp_instr),
      .rsp_addr (rsp_addr),
      .rsp_err  (rsp_err),
      .ld_en    (ld_en),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // Response monitor: a handshake is committed on the edge after a sample with valid && ready
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_rsp: got addr %h required no response", rsp_addr);
            end else begin
               e = exp_q.pop_front();
               check("rsp_instr", rsp_instr, e.instr);
               check("rsp_addr", rsp_addr, e.addr);
               check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
         end
      end
   end

   task automatic load(input logic [7:0] idx, input logic [31:0] data);
      @(posedge clk);
      #1 ld_en = 1'b1; ld_addr = idx; ld_data = data;
      @(posedge clk);
      #1 ld_en = 1'b0;
   endtask

   // Present a request once req_ready is seen; returns 1 time unit after the accepting edge
   task automatic accept(input logic [31:0] a);
      int k;
      k = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (req_ready !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got req_ready %b required 1", req_ready);
      end
      req_valid = 1'b1;
      req_addr  = a;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   // Count edges until rsp_valid is seen
   task automatic wait_valid(input string name, input int lat);
      int k;
      k = 0;
      @(negedge clk);
      while (rsp_valid !== 1'b1 && k < 20) begin
         k++;
         @(negedge clk);
      end
      check(name, 32'(k), 32'(lat));
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (rsp_valid === 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (rsp_valid === 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout: got rsp_valid %b required 0", rsp_valid);
      end
   endtask

   task automatic push_exp(input logic [31:0] instr, input logic [31:0] a, input logic err);
      exp_t e;
      e.instr = instr;
      e.addr  = a;
      e.err   = err;
      exp_q.push_back(e);
   endtask

   task automatic fetch(input logic [31:0] a, input logic [31:0] instr, input logic err,
                        input int lat, input string name);
      push_exp(instr, a, err);
      accept(a);
      wait_valid(name, lat);
      wait_done();
   endtask

   initial begin
      logic [31:0] s_instr;
      logic [31:0] s_addr;
      logic        s_err;
      logic        seen;

      rst       = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      rsp_ready = 1'b1;
      ld_en     = 1'b0;
      ld_addr   = '0;
      ld_data   = '0;

      // Reset held for two edges, then released
      repeat (2) @(posedge clk);
      #1;
      check("req_ready_in_reset", 32'(req_ready), 32'd0);
      check("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_instr", rsp_instr, 32'h0000_0013);
      check("reset_rsp_addr", rsp_addr, 32'd0);
      check("reset_rsp_err", 32'(rsp_err), 32'd0);
      check("reset_req_ready", 32'(req_ready), 32'd1);

      load(8'd4, 32'h0050_0093);
      load(8'd0, 32'h0000_0297);
      load(8'd255, 32'h0000_006F);

      fetch(32'h10, 32'h0050_0093, 1'b0, 3, "lat_word4");
      fetch(32'h0, 32'h0000_0297, 1'b0, 3, "lat_word0");
      fetch(32'h3FC, 32'h0000_006F, 1'b0, 3, "lat_last_word");
      fetch(32'h12, 32'h0000_0013, 1'b1, 1, "lat_misaligned");
      fetch(32'h400, 32'h0000_0013, 1'b1, 1, "lat_out_of_range");
      fetch(32'h8000_0010, 32'h0000_0013, 1'b1, 1, "lat_high_bits");

      // Backpressure: response must hold while rsp_ready is low
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      push_exp(32'h0050_0093, 32'h10, 1'b0);
      accept(32'h10);
      wait_valid("lat_backpressure", 3);
      s_instr = rsp_instr;
      s_addr  = rsp_addr;
      s_err   = rsp_err;
      check("bp_instr_value", s_instr, 32'h0050_0093);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid_hold", 32'(rsp_valid), 32'd1);
         check("bp_instr_hold", rsp_instr, s_instr);
         check("bp_addr_hold", rsp_addr, s_addr);
         check("bp_err_hold", 32'(rsp_err), 32'(s_err));
         check("bp_req_ready_low", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      wait_done();
      check("bp_back_to_idle", 32'(req_ready), 32'd1);

      // Reset pulse while waiting drops the fetch
      accept(32'h10);
      rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("wait_rst_req_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("wait_rst_idle", 32'(req_ready), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) seen = 1'b1;
      end
      check("wait_rst_no_rsp", 32'(seen), 32'd0);
      fetch(32'h10, 32'h0050_0093, 1'b0, 3, "lat_after_rst");

      // Write lands on the capture edge: old word returned, then new word on refetch
      push_exp(32'h0050_0093, 32'h10, 1'b0);
      accept(32'h10);
      @(posedge clk);
      #1 ld_en = 1'b1; ld_addr = 8'd4; ld_data = 32'hDEAD_BEEF;
      @(posedge clk);
      #1 ld_en = 1'b0;
      wait_valid("lat_same_cycle", 1);
      wait_done();
      fetch(32'h10, 32'hDEAD_BEEF, 1'b0, 3, "lat_refetch");

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
